dmem_lsu_ctrl: RTL and testbench

CPU-side load/store controller that initiates all accesses to the synchronous data memory. It accepts one request at a time from the MEM pipeline stage and drives the memory's address, data_in and write_en. It captures data_out one edge after the address is presented, and returns a single-cycle response. Byte stores are built as a read-modify-write sequence, because the memory only writes full words.

---
 rtl/dmem_lsu_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dmem_lsu_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl
// -------------
// Load/store controller sitting between the MEM pipeline stage and the
// synchronous data memory. It takes one request at a time and drives the
// memory's address, data_in and write_en. It returns a single-cycle response
// for every completed access. The memory only writes whole words, so a byte
// store is done as read-modify-write: read the word, merge the new byte into
// one lane, then write the whole word back.
//
// Optional build macro:
//   LSU_SIGNEXT_EN  - when defined, byte loads are sign-extended from bit
//                     DSIZE/2-1. When undefined, byte loads are zero-extended.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   req_valid     request present
//   req_ready     controller can accept a request (high only in IDLE)
//   req_write     1 = store, 0 = load
//   req_byte      1 = byte access, 0 = word access
//   req_hi        byte lane select (1 = upper half, 0 = lower half)
//   req_addr      word address
//   req_wdata     store data (byte stores use the low DSIZE/2 bits)
//   resp_valid    one-cycle completion pulse
//   resp_rdata    load result, held until the next load completes
//   mem_address   memory address
//   mem_data_in   memory write data
//   mem_write_en  memory write enable, active high
//   mem_data_out  memory read data (registered inside the memory)

module dmem_lsu_ctrl #(
    parameter int DSIZE     = 16,
    parameter int MEM_SPACE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic                 req_byte,
    input  logic                 req_hi,
    input  logic [MEM_SPACE-1:0] req_addr,
    input  logic [DSIZE-1:0]     req_wdata,
    output logic                 resp_valid,
    output logic [DSIZE-1:0]     resp_rdata,
    output logic [MEM_SPACE-1:0] mem_address,
    output logic [DSIZE-1:0]     mem_data_in,
    output logic                 mem_write_en,
    input  logic [DSIZE-1:0]     mem_data_out
);

    localparam int BSIZE = DSIZE / 2;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD1,
        RD2,
        RMW1,
        RMW2,
        RMW_WR
    } state_t;

    state_t               state, state_nxt;
    logic                 lat_byte, lat_byte_nxt;
    logic                 lat_hi, lat_hi_nxt;
    logic [BSIZE-1:0]     lat_bdata, lat_bdata_nxt;
    logic                 resp_valid_nxt;
    logic [DSIZE-1:0]     resp_rdata_nxt;
    logic [MEM_SPACE-1:0] mem_address_nxt;
    logic [DSIZE-1:0]     mem_data_in_nxt;
    logic                 mem_write_en_nxt;

    logic [BSIZE-1:0]     lane_data;
    logic [DSIZE-1:0]     load_data;
    logic [DSIZE-1:0]     merged_data;

    assign req_ready = (state == IDLE);

    // Build the load result and the read-modify-write merge from the word
    // that the memory returns. The latched lane select picks the byte. The
    // merge keeps the other lane exactly as it was read.
    always_comb begin
        lane_data = lat_hi ? mem_data_out[DSIZE-1:BSIZE] : mem_data_out[BSIZE-1:0];
`ifdef LSU_SIGNEXT_EN
        load_data = lat_byte ? {{BSIZE{lane_data[BSIZE-1]}}, lane_data} : mem_data_out;
`else
        load_data = lat_byte ? {{BSIZE{1'b0}}, lane_data} : mem_data_out;
`endif
        merged_data = lat_hi ? {lat_bdata, mem_data_out[BSIZE-1:0]}
                             : {mem_data_out[DSIZE-1:BSIZE], lat_bdata};
    end

    // Next-state and next-output logic. Every output register holds its value
    // by default. The exceptions are resp_valid and mem_write_en, which are
    // single-cycle pulses and default to 0. The request fields are captured
    // only at acceptance, so later input changes cannot disturb an access
    // that is in flight.
    always_comb begin
        state_nxt        = state;
        lat_byte_nxt     = lat_byte;
        lat_hi_nxt       = lat_hi;
        lat_bdata_nxt    = lat_bdata;
        resp_valid_nxt   = 1'b0;
        resp_rdata_nxt   = resp_rdata;
        mem_address_nxt  = mem_address;
        mem_data_in_nxt  = mem_data_in;
        mem_write_en_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    mem_address_nxt = req_addr;
                    lat_byte_nxt    = req_byte;
                    lat_hi_nxt      = req_hi;
                    lat_bdata_nxt   = req_wdata[BSIZE-1:0];
                    if (req_write && !req_byte) begin
                        mem_data_in_nxt  = req_wdata;
                        mem_write_en_nxt = 1'b1;
                        state_nxt        = WR;
                    end else if (req_write) begin
                        state_nxt = RMW1;
                    end else begin
                        state_nxt = RD1;
                    end
                end
            end
            WR: begin
                resp_valid_nxt = 1'b1;
                state_nxt      = IDLE;
            end
            RD1:  state_nxt = RD2;
            RD2: begin
                resp_rdata_nxt = load_data;
                resp_valid_nxt = 1'b1;
                state_nxt      = IDLE;
            end
            RMW1: state_nxt = RMW2;
            RMW2: begin
                mem_data_in_nxt  = merged_data;
                mem_write_en_nxt = 1'b1;
                state_nxt        = RMW_WR;
            end
            RMW_WR: begin
                resp_valid_nxt = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers. The asynchronous reset abandons any access
    // that is in flight. It also drops write_en immediately, so an aborted
    // store never reaches the memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            lat_byte     <= 1'b0;
            lat_hi       <= 1'b0;
            lat_bdata    <= '0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            mem_address  <= '0;
            mem_data_in  <= '0;
            mem_write_en <= 1'b0;
        end else begin
            state        <= state_nxt;
            lat_byte     <= lat_byte_nxt;
            lat_hi       <= lat_hi_nxt;
            lat_bdata    <= lat_bdata_nxt;
            resp_valid   <= resp_valid_nxt;
            resp_rdata   <= resp_rdata_nxt;
            mem_address  <= mem_address_nxt;
            mem_data_in  <= mem_data_in_nxt;
            mem_write_en <= mem_write_en_nxt;
        end
    end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// tb_dmem_lsu_ctrl
// ----------------
// Self-checking bench for dmem_lsu_ctrl. A synchronous word memory is
// modelled next to the DUT. Expected results come from a word-array reference
// model that applies each load or store directly, with plain arithmetic.

module tb_dmem_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic        req_hi;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic [7:0]  mem_address;
    logic [15:0] mem_data_in;
    logic        mem_write_en;
    logic [15:0] mem_data_out;

    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    logic [15:0] last_rdata;
    int          checks_total;
    int          checks_passed;

    dmem_lsu_ctrl #(.DSIZE(16), .MEM_SPACE(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_byte     (req_byte),
        .req_hi       (req_hi),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_write_en (mem_write_en),
        .mem_data_out (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input int i);
        return 16'((i * 16'h0137) ^ 16'h5A5A);
    endfunction

    // Synchronous data memory: one registered read port and one write port.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        mem_data_out = '0;
        forever begin
            @(posedge clk);
            if (mem_write_en) mem[mem_address] <= mem_data_in;
            mem_data_out <= mem[mem_address];
        end
    end

    // Reference model: applies one request to ref_mem. It returns the
    // expected response data, the latency in edges after acceptance, and the
    // number of write cycles.
    task automatic model_apply(input logic w, input logic b, input logic h,
                               input logic [7:0] a, input logic [15:0] wd,
                               output logic [15:0] exp_rd, output int exp_lat,
                               output int exp_we);
        int word_val;
        int byte_val;
        word_val = int'(ref_mem[a]);
        exp_rd   = last_rdata;
        if (w) begin
            exp_we = 1;
            if (!b) begin
                ref_mem[a] = wd;
                exp_lat    = 1;
            end else begin
                exp_lat = 3;
                if (h) ref_mem[a] = 16'((word_val % 256) + (int'(wd) % 256) * 256);
                else   ref_mem[a] = 16'((word_val / 256) * 256 + int'(wd) % 256);
            end
        end else begin
            exp_we  = 0;
            exp_lat = 2;
            if (!b) begin
                exp_rd = ref_mem[a];
            end else begin
                byte_val = h ? word_val / 256 : word_val % 256;
`ifdef LSU_SIGNEXT_EN
                if (byte_val >= 128) byte_val = byte_val - 256;
`endif
                exp_rd = 16'(byte_val);
            end
            last_rdata = exp_rd;
        end
    endtask

    // Drives one request and observes it through to its response. The
    // request fields are scrambled after acceptance so that latching is
    // exercised. Makes no comparisons.
    task automatic run_req(input logic w, input logic b, input logic h,
                           input logic [7:0] a, input logic [15:0] wd,
                           output int lat, output logic [15:0] rd,
                           output int we_cnt, output int busy_ready);
        lat = -1; we_cnt = 0; busy_ready = 0; rd = '0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_byte = b; req_hi = h;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom); req_byte = 1'($urandom); req_hi = 1'($urandom);
        req_addr = 8'($urandom); req_wdata = 16'($urandom);
        for (int c = 1; c <= 10; c++) begin
            if (mem_write_en) we_cnt++;
            if (resp_valid) begin
                lat = c - 1;
                rd  = resp_rdata;
                break;
            end
            if (req_ready) busy_ready++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        req_hi = 1'b0; req_addr = '0; req_wdata = '0;
        last_rdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        #1;
        checks_total++; if (req_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", req_ready); else checks_passed++;
        checks_total++; if (resp_valid !== 1'b0) $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); else checks_passed++;
        checks_total++; if (resp_rdata !== 16'h0) $display("[TB] FAIL reset_rdata: got %h expected 0000", resp_rdata); else checks_passed++;
        checks_total++; if (mem_address !== 8'h0) $display("[TB] FAIL reset_addr: got %h expected 00", mem_address); else checks_passed++;
        checks_total++; if (mem_data_in !== 16'h0) $display("[TB] FAIL reset_data_in: got %h expected 0000", mem_data_in); else checks_passed++;
        checks_total++; if (mem_write_en !== 1'b0) $display("[TB] FAIL reset_we: got %b expected 0", mem_write_en); else checks_passed++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_word_store_load();
        logic [15:0] e_rd, rd;
        int e_lat, e_we, lat, we, busy;
        model_apply(1'b1, 1'b0, 1'b0, 8'h10, 16'hBEEF, e_rd, e_lat, e_we);
        run_req(1'b1, 1'b0, 1'b0, 8'h10, 16'hBEEF, lat, rd, we, busy);
        checks_total++; if (lat !== 1) $display("[TB] FAIL wstore_latency: got %0d expected 1", lat); else checks_passed++;
        checks_total++; if (we !== 1) $display("[TB] FAIL wstore_we_cycles: got %0d expected 1", we); else checks_passed++;
        @(negedge clk);
        checks_total++; if (resp_valid !== 1'b0 || mem_write_en !== 1'b0) $display("[TB] FAIL wstore_pulse_end: got valid=%b we=%b expected 0 0", resp_valid, mem_write_en); else checks_passed++;
        model_apply(1'b0, 1'b0, 1'b0, 8'h10, 16'h0, e_rd, e_lat, e_we);
        run_req(1'b0, 1'b0, 1'b0, 8'h10, 16'h0, lat, rd, we, busy);
        checks_total++; if (lat !== 2) $display("[TB] FAIL wload_latency: got %0d expected 2", lat); else checks_passed++;
        checks_total++; if (rd !== 16'hBEEF) $display("[TB] FAIL wload_data: got %h expected beef", rd); else checks_passed++;
        checks_total++; if (we !== 0) $display("[TB] FAIL wload_we_cycles: got %0d expected 0", we); else checks_passed++;
    endtask

    task automatic test_byte_store();
        logic [15:0] e_rd, rd, wd;
        int e_lat, e_we, lat, we, busy;
        wd = {8'($urandom), 8'h5A};
        model_apply(1'b1, 1'b1, 1'b1, 8'h10, wd, e_rd, e_lat, e_we);
        run_req(1'b1, 1'b1, 1'b1, 8'h10, wd, lat, rd, we, busy);
        checks_total++; if (lat !== 3) $display("[TB] FAIL bstore_latency: got %0d expected 3", lat); else checks_passed++;
        checks_total++; if (busy !== 0) $display("[TB] FAIL bstore_ready_busy: got %0d ready cycles expected 0", busy); else checks_passed++;
        checks_total++; if (we !== 1) $display("[TB] FAIL bstore_we_cycles: got %0d expected 1", we); else checks_passed++;
        @(negedge clk);
        checks_total++; if (mem[8'h10] !== 16'h5AEF) $display("[TB] FAIL bstore_mem: got %h expected 5aef", mem[8'h10]); else checks_passed++;
    endtask

    task automatic test_byte_load();
        logic [15:0] e_rd, rd, exp_lo;
        int e_lat, e_we, lat, we, busy;
`ifdef LSU_SIGNEXT_EN
        exp_lo = 16'hFFF0;
`else
        exp_lo = 16'h00F0;
`endif
        model_apply(1'b1, 1'b0, 1'b0, 8'h20, 16'h12F0, e_rd, e_lat, e_we);
        run_req(1'b1, 1'b0, 1'b0, 8'h20, 16'h12F0, lat, rd, we, busy);
        model_apply(1'b0, 1'b1, 1'b0, 8'h20, 16'h0, e_rd, e_lat, e_we);
        run_req(1'b0, 1'b1, 1'b0, 8'h20, 16'h0, lat, rd, we, busy);
        checks_total++; if (rd !== exp_lo) $display("[TB] FAIL bload_lo: got %h expected %h", rd, exp_lo); else checks_passed++;
        checks_total++; if (lat !== 2) $display("[TB] FAIL bload_latency: got %0d expected 2", lat); else checks_passed++;
        model_apply(1'b0, 1'b1, 1'b1, 8'h20, 16'h0, e_rd, e_lat, e_we);
        run_req(1'b0, 1'b1, 1'b1, 8'h20, 16'h0, lat, rd, we, busy);
        checks_total++; if (rd !== 16'h0012) $display("[TB] FAIL bload_hi: got %h expected 0012", rd); else checks_passed++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] e_rd, d;
        int e_lat, e_we, lat;
        d = 16'($urandom);
        model_apply(1'b1, 1'b0, 1'b0, 8'h40, d, e_rd, e_lat, e_we);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_hi = 1'b0;
        req_addr = 8'h40; req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            if (resp_valid) break;
            @(negedge clk);
        end
        checks_total++; if (resp_valid !== 1'b1 || req_ready !== 1'b1) $display("[TB] FAIL b2b_ready_with_resp: got valid=%b ready=%b expected 1 1", resp_valid, req_ready); else checks_passed++;
        model_apply(1'b0, 1'b0, 1'b0, 8'h40, 16'h0, e_rd, e_lat, e_we);
        req_write = 1'b0; req_wdata = 16'($urandom);
        @(posedge clk);
        @(negedge clk);
        checks_total++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) $display("[TB] FAIL b2b_second_accepted: got ready=%b valid=%b expected 0 0", req_ready, resp_valid); else checks_passed++;
        req_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            if (resp_valid) begin
                lat = c - 1;
                break;
            end
            @(negedge clk);
        end
        checks_total++; if (lat !== 2) $display("[TB] FAIL b2b_load_latency: got %0d expected 2", lat); else checks_passed++;
        checks_total++; if (resp_rdata !== e_rd) $display("[TB] FAIL b2b_load_data: got %h expected %h", resp_rdata, e_rd); else checks_passed++;
    endtask

    task automatic test_addr_wrap();
        logic [15:0] e_rd, rd;
        int e_lat, e_we, lat, we, busy;
        model_apply(1'b1, 1'b0, 1'b0, 8'hFF, 16'hA5A5, e_rd, e_lat, e_we);
        run_req(1'b1, 1'b0, 1'b0, 8'hFF, 16'hA5A5, lat, rd, we, busy);
        model_apply(1'b0, 1'b0, 1'b0, 8'hFF, 16'h0, e_rd, e_lat, e_we);
        run_req(1'b0, 1'b0, 1'b0, 8'hFF, 16'h0, lat, rd, we, busy);
        checks_total++; if (rd !== 16'hA5A5) $display("[TB] FAIL wrap_ff: got %h expected a5a5", rd); else checks_passed++;
        model_apply(1'b0, 1'b0, 1'b0, 8'h00, 16'h0, e_rd, e_lat, e_we);
        run_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0, lat, rd, we, busy);
        checks_total++; if (rd !== e_rd) $display("[TB] FAIL wrap_00: got %h expected %h", rd, e_rd); else checks_passed++;
    endtask

    task automatic test_reset_mid_rmw();
        logic [15:0] e_rd, rd;
        int e_lat, e_we, lat, we, busy, we_seen, resp_seen;
        model_apply(1'b1, 1'b0, 1'b0, 8'h30, 16'h1234, e_rd, e_lat, e_we);
        run_req(1'b1, 1'b0, 1'b0, 8'h30, 16'h1234, lat, rd, we, busy);
        we_seen = 0; resp_seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1; req_hi = 1'b1;
        req_addr = 8'h30; req_wdata = 16'($urandom);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (mem_write_en) we_seen++;
        if (resp_valid) resp_seen++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks_total++; if (mem_write_en !== 1'b0 || resp_valid !== 1'b0) $display("[TB] FAIL rmw_reset_outputs: got we=%b valid=%b expected 0 0", mem_write_en, resp_valid); else checks_passed++;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) rst = 1'b1;
            @(negedge clk);
            if (mem_write_en) we_seen++;
            if (resp_valid) resp_seen++;
        end
        last_rdata = '0;
        checks_total++; if (we_seen !== 0) $display("[TB] FAIL rmw_reset_we: got %0d write cycles expected 0", we_seen); else checks_passed++;
        checks_total++; if (resp_seen !== 0) $display("[TB] FAIL rmw_reset_resp: got %0d responses expected 0", resp_seen); else checks_passed++;
        checks_total++; if (mem[8'h30] !== 16'h1234) $display("[TB] FAIL rmw_reset_mem: got %h expected 1234", mem[8'h30]); else checks_passed++;
        checks_total++; if (req_ready !== 1'b1 || resp_rdata !== 16'h0) $display("[TB] FAIL rmw_reset_idle: got ready=%b rdata=%h expected 1 0000", req_ready, resp_rdata); else checks_passed++;
    endtask

    task automatic test_random();
        logic [15:0] e_rd, rd, wd;
        logic [7:0]  a;
        logic        w, b, h;
        int e_lat, e_we, lat, we, busy, sel;
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 9));
            a   = (sel > 7) ? 8'(246 + sel) : 8'(sel);
            w   = 1'($urandom); b = 1'($urandom); h = 1'($urandom);
            wd  = 16'($urandom);
            model_apply(w, b, h, a, wd, e_rd, e_lat, e_we);
            run_req(w, b, h, a, wd, lat, rd, we, busy);
            checks_total++; if (lat !== e_lat) $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, e_lat); else checks_passed++;
            checks_total++; if (we !== e_we) $display("[TB] FAIL rand_we_cycles[%0d]: got %0d expected %0d", n, we, e_we); else checks_passed++;
            checks_total++; if (busy !== 0) $display("[TB] FAIL rand_ready_busy[%0d]: got %0d expected 0", n, busy); else checks_passed++;
            checks_total++; if (rd !== e_rd) $display("[TB] FAIL rand_rdata[%0d]: got %h expected %h", n, rd, e_rd); else checks_passed++;
        end
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            a = (i > 7) ? 8'(246 + i) : 8'(i);
            checks_total++; if (mem[a] !== ref_mem[a]) $display("[TB] FAIL rand_mem[%h]: got %h expected %h", a, mem[a], ref_mem[a]); else checks_passed++;
        end
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        test_reset();
        test_word_store_load();
        test_byte_store();
        test_byte_load();
        test_back_to_back();
        test_addr_wrap();
        test_reset_mid_rmw();
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
